// File: rtl/spu_sm_reci_norm.sv
// Softmax normalizer: accumulates exp lanes, computes 2^RECI_W / sum by
// restoring division, then scales exp lanes into 8-bit probabilities.
//
// Ports:
//   core_clk            sole clock, rising edge
//   rst                 synchronous active-high reset
//   sm_state[2:0]       softmax phase: IDLE=000 EU_STAGE_A=001 RECI=011
//                       EU_STAGE_B=100 MAX=101 (MAX and unlisted codes hold state)
//   exp_valid           exp lanes valid this cycle
//   exp_q_0..exp_q_3    unsigned 8-bit exp-unit outputs
//   reci_done           reciprocal ready, level until sm_state returns to IDLE
//   sum_ovf             sticky accumulator saturation flag
//   dout_valid          normalized lanes valid (one cycle after the input beat)
//   dout_q_0..dout_q_3  probabilities, scale 2^-8
module spu_sm_reci_norm #(
    parameter int SUM_W  = 18,
    parameter int RECI_W = 24
) (
    input  logic       core_clk,
    input  logic       rst,
    input  logic [2:0] sm_state,
    input  logic       exp_valid,
    input  logic [7:0] exp_q_0,
    input  logic [7:0] exp_q_1,
    input  logic [7:0] exp_q_2,
    input  logic [7:0] exp_q_3,
    output logic       reci_done,
    output logic       sum_ovf,
    output logic       dout_valid,
    output logic [7:0] dout_q_0,
    output logic [7:0] dout_q_1,
    output logic [7:0] dout_q_2,
    output logic [7:0] dout_q_3
);

    localparam logic [2:0] SM_IDLE = 3'b000;
    localparam logic [2:0] SM_EU_A = 3'b001;
    localparam logic [2:0] SM_RECI = 3'b011;
    localparam logic [2:0] SM_EU_B = 3'b100;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(RECI_W + 1);

    logic [1:0]        fsm;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  rem;
    logic [RECI_W:0]   quo;
    logic [CNT_W-1:0]  cnt;
    logic [RECI_W-1:0] recip;

    // Four-lane add; the carry bit of acc_full flags saturation.
    logic [9:0]       lane_sum;
    logic [SUM_W:0]   acc_full;

    assign lane_sum = {2'b0, exp_q_0} + {2'b0, exp_q_1}
                    + {2'b0, exp_q_2} + {2'b0, exp_q_3};
    assign acc_full = {1'b0, sum} + (SUM_W + 1)'(lane_sum);

    // One restoring-division step. The dividend 2^RECI_W is a single 1
    // followed by zeros, so the start cycle shifts in the 1 and performs
    // the first iteration itself. With sum==0 every trial succeeds and the
    // quotient fills with ones, which saturates naturally.
    logic              div_start;
    logic [SUM_W-1:0]  rem_in;
    logic [RECI_W:0]   quo_in;
    logic [SUM_W:0]    trial;
    logic              q_bit;
    logic [SUM_W-1:0]  rem_nxt;
    logic [RECI_W:0]   quo_nxt;
    logic [RECI_W-1:0] recip_nxt;

    assign div_start = (sm_state == SM_RECI)
                    && (fsm == S_IDLE || fsm == S_ACC);

    always_comb begin
        rem_in    = div_start ? '0 : rem;
        quo_in    = div_start ? '0 : quo;
        trial     = {rem_in, div_start};
        q_bit     = (trial >= {1'b0, sum});
        rem_nxt   = q_bit ? SUM_W'(trial - {1'b0, sum})
                          : trial[SUM_W-1:0];
        quo_nxt   = {quo_in[RECI_W-1:0], q_bit};
        recip_nxt = quo_nxt[RECI_W] ? '1 : quo_nxt[RECI_W-1:0];
    end

    function automatic logic [7:0] norm(input logic [7:0] e,
                                        input logic [RECI_W-1:0] r);
        logic [31:0] p;
        p = 32'(e) * 32'(r);
        return (p[31:24] != 8'd0) ? 8'hff : p[23:16];
    endfunction

    always_ff @(posedge core_clk) begin
        if (rst) begin
            fsm        <= S_IDLE;
            sum        <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            recip      <= '0;
            sum_ovf    <= 1'b0;
            reci_done  <= 1'b0;
            dout_valid <= 1'b0;
            dout_q_0   <= '0;
            dout_q_1   <= '0;
            dout_q_2   <= '0;
            dout_q_3   <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (sm_state == SM_IDLE) begin
                fsm       <= S_IDLE;
                sum       <= '0;
                sum_ovf   <= 1'b0;
                reci_done <= 1'b0;
            end else if (fsm == S_DIV && sm_state != SM_RECI) begin
                // Abort: previous reciprocal is kept.
                fsm       <= S_IDLE;
                sum       <= '0;
                reci_done <= 1'b0;
            end else begin
                case (fsm)
                    S_IDLE, S_ACC: begin
                        if (sm_state == SM_EU_A && exp_valid) begin
                            fsm <= S_ACC;
                            if (acc_full[SUM_W]) begin
                                sum     <= '1;
                                sum_ovf <= 1'b1;
                            end else begin
                                sum <= acc_full[SUM_W-1:0];
                            end
                        end else if (div_start) begin
                            fsm <= S_DIV;
                            rem <= rem_nxt;
                            quo <= quo_nxt;
                            cnt <= CNT_W'(1);
                        end
                    end
                    S_DIV: begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(RECI_W)) begin
                            recip     <= recip_nxt;
                            reci_done <= 1'b1;
                            fsm       <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (sm_state == SM_EU_B && exp_valid) begin
                            dout_q_0   <= norm(exp_q_0, recip);
                            dout_q_1   <= norm(exp_q_1, recip);
                            dout_q_2   <= norm(exp_q_2, recip);
                            dout_q_3   <= norm(exp_q_3, recip);
                            dout_valid <= 1'b1;
                        end
                    end
                    default: fsm <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spu_sm_reci_norm.sv
// Self-checking bench for spu_sm_reci_norm: scoreboard of expected
// normalized beats plus directed checks of reciprocal timing and flags.
module tb_spu_sm_reci_norm;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_EU_A = 3'b001;
    localparam logic [2:0] ST_RECI = 3'b011;
    localparam logic [2:0] ST_EU_B = 3'b100;
    localparam logic [2:0] ST_MAX  = 3'b101;
    localparam longint RMAX = 64'd16777215;
    localparam longint SMAX = 64'd262143;

    logic       core_clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sm_state = ST_IDLE;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_q_0 = '0, exp_q_1 = '0, exp_q_2 = '0, exp_q_3 = '0;
    logic       reci_done, sum_ovf, dout_valid;
    logic [7:0] dout_q_0, dout_q_1, dout_q_2, dout_q_3;

    spu_sm_reci_norm dut (
        .core_clk  (core_clk),
        .rst       (rst),
        .sm_state  (sm_state),
        .exp_valid (exp_valid),
        .exp_q_0   (exp_q_0),
        .exp_q_1   (exp_q_1),
        .exp_q_2   (exp_q_2),
        .exp_q_3   (exp_q_3),
        .reci_done (reci_done),
        .sum_ovf   (sum_ovf),
        .dout_valid(dout_valid),
        .dout_q_0  (dout_q_0),
        .dout_q_1  (dout_q_1),
        .dout_q_2  (dout_q_2),
        .dout_q_3  (dout_q_3)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } exp_t;

    exp_t   sb[$];
    exp_t   ent;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    longint m_sum = 0;
    longint m_recip = 0;
    bit     m_done = 0;

    always @(posedge core_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t",
                     tag, got, got, exp, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge core_clk) begin
        if (dout_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_dout_valid", 32'd1, 32'd0);
            end else begin
                ent = sb.pop_front();
                chk("dout", {dout_q_3, dout_q_2, dout_q_1, dout_q_0}, ent.d);
                chk("dout_latency", cyc, ent.cyc);
            end
        end
    end

    function automatic longint recip_of(input longint s);
        longint q;
        if (s == 0) return RMAX;
        q = 64'd16777216 / s;
        return (q > RMAX) ? RMAX : q;
    endfunction

    function automatic logic [7:0] dout_of(input logic [7:0] e,
                                           input longint r);
        longint p;
        p = (longint'(e) * r) >> 16;
        return (p > 255) ? 8'd255 : p[7:0];
    endfunction

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic v,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        sm_state  = st;
        exp_valid = v;
        exp_q_0 = a; exp_q_1 = b; exp_q_2 = c; exp_q_3 = d;
    endtask

    task automatic beat_a(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        drive(ST_EU_A, 1'b1, a, b, c, d);
        m_sum = m_sum + a + b + c + d;
        if (m_sum > SMAX) m_sum = SMAX;
        tick();
    endtask

    task automatic beat_b(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        exp_t x;
        drive(ST_EU_B, 1'b1, a, b, c, d);
        if (m_done) begin
            x.cyc = cyc + 1;
            x.d = {dout_of(d, m_recip), dout_of(c, m_recip),
                   dout_of(b, m_recip), dout_of(a, m_recip)};
            sb.push_back(x);
        end
        tick();
    endtask

    task automatic run_reci();
        int n;
        n = 0;
        drive(ST_RECI, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        while (n < 40 && !reci_done) begin
            tick();
            n++;
        end
        chk("reci_done_cycle", reci_done ? 32'(n + 1) : 32'd0, 32'd26);
        m_recip = recip_of(m_sum);
        m_done  = reci_done;
    endtask

    task automatic go_idle();
        drive(ST_IDLE, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("idle_reci_done", {31'd0, reci_done}, 32'd0);
        chk("idle_sum_ovf", {31'd0, sum_ovf}, 32'd0);
        m_sum  = 0;
        m_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_reci_done", {31'd0, reci_done}, 32'd0);
        chk("rst_sum_ovf", {31'd0, sum_ovf}, 32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout", {dout_q_3, dout_q_2, dout_q_1, dout_q_0}, 32'd0);
        rst = 1'b0;
        go_idle();

        // Nominal: sum 512, recip 32768
        beat_a(8'd64, 8'd64, 8'd64, 8'd64);
        beat_a(8'd64, 8'd64, 8'd64, 8'd64);
        run_reci();
        tick();
        chk("reci_done_hold", {31'd0, reci_done}, 32'd1);
        beat_b(8'd64, 8'd128, 8'd0, 8'd255);
        drive(ST_MAX, 1'b1, 8'd9, 8'd9, 8'd9, 8'd9);
        tick();
        beat_a(8'd200, 8'd200, 8'd200, 8'd200);
        beat_b(8'd10, 8'd20, 8'd30, 8'd40);
        chk("nominal_sum_ovf", {31'd0, sum_ovf}, 32'd0);
        go_idle();

        // Minimum sum: recip saturates
        beat_a(8'd1, 8'd0, 8'd0, 8'd0);
        run_reci();
        beat_b(8'd1, 8'd0, 8'd0, 8'd0);
        go_idle();

        // Reset during division with RECI held
        beat_a(8'd5, 8'd5, 8'd5, 8'd5);
        drive(ST_RECI, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        chk("mid_rst_reci_done", {31'd0, reci_done}, 32'd0);
        chk("mid_rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("mid_rst_dout", {dout_q_3, dout_q_2, dout_q_1, dout_q_0}, 32'd0);
        rst = 1'b0;
        m_sum  = 0;
        m_done = 0;
        run_reci();
        beat_b(8'd1, 8'd2, 8'd3, 8'd4);
        go_idle();

        // Zero sum
        run_reci();
        beat_b(8'd0, 8'd0, 8'd0, 8'd0);
        beat_b(8'd3, 8'd0, 8'd1, 8'd0);
        go_idle();

        // Overflow: saturated sum, recip 64
        for (int i = 0; i < 300; i++)
            beat_a(8'd255, 8'd255, 8'd255, 8'd255);
        chk("ovf_flag", {31'd0, sum_ovf}, 32'd1);
        run_reci();
        chk("ovf_recip", 32'(m_recip), 32'd64);
        beat_b(8'd255, 8'd255, 8'd255, 8'd255);
        go_idle();

        // Abort: leave RECI at cycle 10
        beat_a(8'd10, 8'd10, 8'd10, 8'd10);
        drive(ST_RECI, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 9; i++) tick();
        m_done = 0;
        beat_b(8'd50, 8'd60, 8'd70, 8'd80);
        beat_b(8'd50, 8'd60, 8'd70, 8'd80);
        beat_b(8'd50, 8'd60, 8'd70, 8'd80);
        for (int i = 0; i < 30; i++) tick();
        chk("abort_reci_done", {31'd0, reci_done}, 32'd0);
        go_idle();

        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
